// File: rtl/seg_scan_decoder.sv
// Scanned 7-segment bus decoder.
// Watches a multiplexed active-low segment bus with a one-hot digit select,
// waits for each select/pattern pair to hold steady, then commits the decoded
// operand code into that digit's slot. Publishes per-digit codes, error flags
// and a single-cycle pulse once every digit has been committed in a frame.
module seg_scan_decoder #(
    parameter int DIGITS        = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   code_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int SW = DIGITS + 7;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [SW-1:0]      sample_reg;
    logic [CW-1:0]      cnt_reg;
    logic [DIGITS-1:0]  seen_reg;
    logic               frame_valid_reg;

    logic [SW-1:0]      sample;
    logic               sample_valid;
    logic               same_sample;
    logic               commit;
    logic [DIGITS-1:0]  seen_next;
    logic [3:0]         seg_code;
    logic               seg_err;

    assign sample       = {dig_sel, seg_in};
    // Exactly one select line high: non-zero and no second bit set.
    assign sample_valid = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    assign same_sample  = (sample == sample_reg);
    // Commit fires on the edge that sees the STABLE_CYCLES-th identical sample.
    assign commit       = (state_reg == SETTLE) && sample_valid && same_sample
                          && (cnt_reg == CNT_LAST);
    assign seen_next    = seen_reg | dig_sel;
    assign frame_valid  = frame_valid_reg;

    // Segment pattern to operand code; unknown patterns read as blank with error.
    always_comb begin
        seg_code = 4'hE;
        seg_err  = 1'b0;
        case (seg_in)
            7'b1000000: seg_code = 4'h0;
            7'b1111001: seg_code = 4'h1;
            7'b0100100: seg_code = 4'h2;
            7'b0110000: seg_code = 4'h3;
            7'b0011001: seg_code = 4'h4;
            7'b0010010: seg_code = 4'h5;
            7'b0000010: seg_code = 4'h6;
            7'b1111000: seg_code = 4'h7;
            7'b0000000: seg_code = 4'h8;
            7'b0010000: seg_code = 4'h9;
            7'b0111111: seg_code = 4'hF;
            7'b1111111: seg_code = 4'hE;
            default: begin
                seg_code = 4'hE;
                seg_err  = 1'b1;
            end
        endcase
    end

    // Stability FSM: latch a valid sample, count identical repeats, hold after commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            sample_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sample_valid) begin
                        sample_reg <= sample;
                        cnt_reg    <= CW'(1);
                        state_reg  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!sample_valid) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (!same_sample) begin
                        sample_reg <= sample;
                        cnt_reg    <= CW'(1);
                    end else if (cnt_reg < CNT_LAST) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end else begin
                        state_reg <= HELD;
                    end
                end
                HELD: begin
                    if (!sample_valid) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (!same_sample) begin
                        sample_reg <= sample;
                        cnt_reg    <= CW'(1);
                        state_reg  <= SETTLE;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Frame tracking: pulse when a commit completes the seen-mask, then start afresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_reg        <= '0;
            frame_valid_reg <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            if (commit) begin
                if (&seen_next) begin
                    seen_reg        <= '0;
                    frame_valid_reg <= 1'b1;
                end else begin
                    seen_reg <= seen_next;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] code_reg;
            logic       err_reg;

            // Only the digit selected at commit time takes the new code/err.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    code_reg <= 4'hE;
                    err_reg  <= 1'b0;
                end else if (commit && dig_sel[gi]) begin
                    code_reg <= seg_code;
                    err_reg  <= seg_err;
                end
            end

            assign code_out[4*gi +: 4] = code_reg;
            assign err_out[gi]         = err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed bench for seg_scan_decoder. The reference model
// treats the bus as runs of identical valid samples: a digit is committed when
// its run length reaches exactly STABLE_CYCLES.
module tb_seg_scan_decoder;

    localparam int DIGITS = 6;
    localparam int STABLE = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [6:0]           seg_in;
    logic [DIGITS-1:0]    dig_sel;
    logic [4*DIGITS-1:0]  code_out;
    logic [DIGITS-1:0]    err_out;
    logic                 frame_valid;

    seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .code_out    (code_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [6:0]        pat_tab  [12] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111};
    logic [3:0]        code_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                         4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'hE};
    logic [3:0]        m_code   [DIGITS];
    logic [DIGITS-1:0] m_err;
    logic [DIGITS-1:0] m_seen;
    logic              m_fv;
    logic [12:0]       m_last;
    int                m_run;
    int                obs_frames;
    logic              prev_fv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 12; k++)
            if (pat_tab[k] == s) return {1'b0, code_tab[k]};
        return {1'b1, 4'hE};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < DIGITS; d++) m_code[d] = 4'hE;
        m_err  = '0;
        m_seen = '0;
        m_fv   = 1'b0;
        m_last = '0;
        m_run  = 0;
        prev_fv = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now on the bus.
    task automatic model_edge();
        logic [4:0] dec;
        int idx;
        m_fv = 1'b0;
        if ($countones(dig_sel) != 1) begin
            m_run = 0;
        end else if (m_run > 0 && {dig_sel, seg_in} == m_last) begin
            m_run++;
        end else begin
            m_run  = 1;
            m_last = {dig_sel, seg_in};
        end
        if (m_run == STABLE) begin
            idx = 0;
            for (int d = 0; d < DIGITS; d++) if (dig_sel[d]) idx = d;
            dec = ref_decode(seg_in);
            m_code[idx] = dec[3:0];
            m_err[idx]  = dec[4];
            m_seen[idx] = 1'b1;
            if (&m_seen) begin
                m_fv   = 1'b1;
                m_seen = '0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [4*DIGITS-1:0] exp_code;
        for (int d = 0; d < DIGITS; d++) exp_code[4*d +: 4] = m_code[d];
        check_val({tag, "_code"}, 32'(code_out), 32'(exp_code));
        check_val({tag, "_err"}, 32'(err_out), 32'(m_err));
        check_val({tag, "_fv"}, 32'(frame_valid), 32'(m_fv));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (prev_fv) check_val("fv_double", 32'(frame_valid), 32'd0);
        prev_fv = frame_valid;
        if (frame_valid) obs_frames++;
    endtask

    task automatic hold(input string tag, input logic [DIGITS-1:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        $display("txn %s sel=%b seg=%b edges=%0d", tag, sel, seg, n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("txn %s reset pulse", tag);
    endtask

    initial begin
        int frames_before;
        reset      = 1'b1;
        seg_in     = 7'h7F;
        dig_sel    = '0;
        obs_frames = 0;
        model_reset();
        #2;
        check_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Idle bus
        hold("idle", 6'b000000, 7'h7F, 20);

        // Single commit and long dwell
        hold("dig0_two", 6'b000001, 7'b0100100, 4);
        check_val("dig0_is_2", 32'(code_out[3:0]), 32'h2);
        hold("dig0_dwell", 6'b000001, 7'b0100100, 10);

        // Full scan
        frames_before = obs_frames;
        hold("scan0", 6'b000001, 7'b0010000, 4);
        hold("scan1", 6'b000010, 7'b1111001, 4);
        hold("scan2", 6'b000100, 7'b0111111, 4);
        hold("scan3", 6'b001000, 7'b1000000, 4);
        hold("scan4", 6'b010000, 7'b1111000, 4);
        hold("scan5", 6'b100000, 7'b1111111, 4);
        check_val("scan_codes", 32'(code_out), 32'hE70F19);
        check_val("scan_frames", 32'(obs_frames - frames_before), 32'd1);

        // Glitch on digit 3, then multi-hot select
        hold("glitch_a", 6'b001000, 7'b0110000, 3);
        hold("glitch_b", 6'b001000, 7'b0000000, 1);
        hold("glitch_c", 6'b001000, 7'b0110000, 4);
        check_val("glitch_dig3", 32'(code_out[15:12]), 32'h3);
        hold("multihot", 6'b000011, 7'b1111001, 8);

        // Unrecognised pattern then recovery on digit 2
        hold("bad2", 6'b000100, 7'b1010101, 4);
        check_val("bad2_code", 32'(code_out[11:8]), 32'hE);
        check_val("bad2_err", 32'(err_out[2]), 32'd1);
        hold("fix2", 6'b000100, 7'b0010010, 4);
        check_val("fix2_code", 32'(code_out[11:8]), 32'h5);
        check_val("fix2_err", 32'(err_out[2]), 32'd0);

        // Reset mid-frame after five commits
        do_reset("rst_a");
        for (int d = 0; d < 5; d++) hold("pre", 6'(1 << d), pat_tab[d], 4);
        do_reset("rst_mid");
        frames_before = obs_frames;
        for (int d = 0; d < 5; d++) hold("post", 6'(1 << d), pat_tab[d + 4], 4);
        check_val("post5_noframe", 32'(obs_frames - frames_before), 32'd0);
        hold("post5", 6'b100000, pat_tab[9], 4);
        check_val("post6_frame", 32'(obs_frames - frames_before), 32'd1);

        // Random dwells
        for (int t = 0; t < 80; t++) begin
            logic [DIGITS-1:0] sel;
            logic [6:0] seg;
            if ($urandom_range(0, 9) == 0) sel = 6'($urandom_range(0, 63));
            else sel = 6'(1 << $urandom_range(0, DIGITS - 1));
            if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
            else seg = pat_tab[$urandom_range(0, 11)];
            hold("rnd", sel, seg, $urandom_range(1, 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
